// File: rtl/openfire_mem_responder.sv
// Arbitrates openfire_cpu instruction fetches and data loads/stores onto one
// single-port, byte-enabled synchronous RAM and returns data with done pulses.
module openfire_mem_responder #(
    parameter int ADDR_WIDTH    = 12,
    parameter int RAM_LATENCY   = 1,
    parameter int DATA_PRIORITY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           imem_addr,
    input  logic                  imem_re,
    output logic [31:0]           imem_data_in,
    output logic                  imem_done,
    input  logic [31:0]           dmem_addr,
    input  logic [31:0]           dmem_data_out,
    input  logic                  dmem_we,
    input  logic                  dmem_re,
    input  logic [1:0]            dmem_input_sel,
    output logic [31:0]           dmem_data_in,
    output logic                  dmem_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_en,
    output logic [3:0]            ram_be,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic [1:0]            fsm_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_BYTE  = 2'b10;
    localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY - 1);
    localparam logic       PRIO_DATA = (DATA_PRIORITY != 0);

    logic [1:0]  state;
    logic        owner_data;
    logic        lat_store;
    logic [1:0]  lat_lane;
    logic [1:0]  lat_size;
    logic [1:0]  wait_cnt;
    // Set when the priority side won the most recent contended arbitration.
    logic        prio_won;

    logic        dmem_req;
    logic        contend;
    logic        pick_data;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        sel_store;
    logic [3:0]  next_be;
    logic [31:0] next_wdata;
    logic [31:0] load_val;
    logic        unused_addr_bits;

    assign fsm_state = state;
    assign dmem_req  = dmem_re | dmem_we;
    assign contend   = imem_re & dmem_req;
    assign unused_addr_bits = ^{imem_addr[31:ADDR_WIDTH+2], dmem_addr[31:ADDR_WIDTH+2]};

    // Contention alternates owners so neither side can starve the other.
    always_comb begin
        pick_data = dmem_req;
        if (contend) pick_data = PRIO_DATA ^ prio_won;
    end

    assign sel_addr  = pick_data ? dmem_addr : imem_addr;
    assign sel_size  = pick_data ? dmem_input_sel : 2'b00;
    assign sel_store = pick_data & dmem_we & ~dmem_re;

    always_comb begin
        next_be    = 4'b0000;
        next_wdata = 32'h0;
        if (sel_store) begin
            case (sel_size)
                SZ_HALF: begin
                    next_be    = sel_addr[1] ? 4'b0011 : 4'b1100;
                    next_wdata = {2{dmem_data_out[15:0]}};
                end
                SZ_BYTE: begin
                    next_be    = 4'b1000 >> sel_addr[1:0];
                    next_wdata = {4{dmem_data_out[7:0]}};
                end
                default: begin
                    next_be    = 4'b1111;
                    next_wdata = dmem_data_out;
                end
            endcase
        end
    end

    // Big-endian lane select, right-justified and zero-extended.
    always_comb begin
        load_val = ram_rdata;
        case (lat_size)
            SZ_HALF: load_val = lat_lane[1] ? {16'h0, ram_rdata[15:0]} : {16'h0, ram_rdata[31:16]};
            SZ_BYTE: begin
                case (lat_lane)
                    2'd0:    load_val = {24'h0, ram_rdata[31:24]};
                    2'd1:    load_val = {24'h0, ram_rdata[23:16]};
                    2'd2:    load_val = {24'h0, ram_rdata[15:8]};
                    default: load_val = {24'h0, ram_rdata[7:0]};
                endcase
            end
            default: load_val = ram_rdata;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            owner_data   <= 1'b0;
            lat_store    <= 1'b0;
            lat_lane     <= 2'd0;
            lat_size     <= 2'd0;
            wait_cnt     <= 2'd0;
            prio_won     <= 1'b0;
            imem_done    <= 1'b0;
            dmem_done    <= 1'b0;
            imem_data_in <= 32'h0;
            dmem_data_in <= 32'h0;
            ram_en       <= 1'b0;
            ram_be       <= 4'b0000;
            ram_addr     <= '0;
            ram_wdata    <= 32'h0;
        end else begin
            ram_en    <= 1'b0;
            imem_done <= 1'b0;
            dmem_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (imem_re || dmem_req) begin
                        owner_data <= pick_data;
                        lat_store  <= sel_store;
                        lat_lane   <= sel_addr[1:0];
                        lat_size   <= sel_size;
                        ram_en     <= 1'b1;
                        ram_addr   <= sel_addr[ADDR_WIDTH+1:2];
                        ram_be     <= next_be;
                        ram_wdata  <= next_wdata;
                        if (contend) prio_won <= ~prio_won;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ram_be <= 4'b0000;
                    if (lat_store) begin
                        dmem_done <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= 2'd0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == LAT_LAST) begin
                        if (owner_data) begin
                            dmem_data_in <= load_val;
                            dmem_done    <= 1'b1;
                        end else begin
                            imem_data_in <= ram_rdata;
                            imem_done    <= 1'b1;
                        end
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_openfire_mem_responder.sv
// Directed bench for openfire_mem_responder with a one-cycle-latency RAM model.
module tb_openfire_mem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_re;
    logic [31:0] imem_data_in;
    logic        imem_done;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data_out;
    logic        dmem_we;
    logic        dmem_re;
    logic [1:0]  dmem_input_sel;
    logic [31:0] dmem_data_in;
    logic        dmem_done;
    logic [11:0] ram_addr;
    logic        ram_en;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:4095];
    logic        pl_we;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    logic [3:0]  be_seen;
    logic [31:0] wd_seen;
    logic [11:0] ra_seen;
    int          en_cnt;

    openfire_mem_responder dut (
        .clock(clk), .reset(rst),
        .imem_addr(imem_addr), .imem_re(imem_re), .imem_data_in(imem_data_in), .imem_done(imem_done),
        .dmem_addr(dmem_addr), .dmem_data_out(dmem_data_out), .dmem_we(dmem_we), .dmem_re(dmem_re),
        .dmem_input_sel(dmem_input_sel), .dmem_data_in(dmem_data_in), .dmem_done(dmem_done),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_be(ram_be), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read data valid one clock after ram_en
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        if (ram_en) begin
            if (ram_be == 4'b0000) ram_rdata <= mem[ram_addr];
            if (ram_be[3]) mem[ram_addr][31:24] <= ram_wdata[31:24];
            if (ram_be[2]) mem[ram_addr][23:16] <= ram_wdata[23:16];
            if (ram_be[1]) mem[ram_addr][15:8]  <= ram_wdata[15:8];
            if (ram_be[0]) mem[ram_addr][7:0]   <= ram_wdata[7:0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    // one access; returns clocks from the sampling edge to done
    task automatic access(input logic is_imem, input logic [31:0] addr, input logic we,
                          input logic re, input logic [1:0] sel, input logic [31:0] wd,
                          output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        en_cnt = 0;
        if (is_imem) begin
            imem_addr = addr; imem_re = 1'b1;
        end else begin
            dmem_addr = addr; dmem_we = we; dmem_re = re;
            dmem_input_sel = sel; dmem_data_out = wd;
        end
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (ram_en) begin
                en_cnt++;
                be_seen = ram_be; wd_seen = ram_wdata; ra_seen = ram_addr;
            end
            if (is_imem ? imem_done : dmem_done) got = 1'b1;
        end
        imem_re = 1'b0; dmem_we = 1'b0; dmem_re = 1'b0;
        tick();
    endtask

    initial begin
        int cyc;
        int d_cyc;
        int i_cyc;
        int d_cnt;
        int i_cnt;

        rst = 1'b1;
        imem_addr = 0; imem_re = 0; dmem_addr = 0; dmem_data_out = 0;
        dmem_we = 0; dmem_re = 0; dmem_input_sel = 0;
        pl_we = 0; pl_addr = 0; pl_data = 0;
        tick();
        chk("rst_state", {30'h0, fsm_state}, 32'd0);
        chk("rst_ram_en", {31'h0, ram_en}, 32'd0);
        chk("rst_dones", {30'h0, imem_done, dmem_done}, 32'd0);
        preload(12'd3, 32'hDEADBEEF);
        preload(12'd4, 32'h11223344);
        preload(12'd5, 32'h12345678);
        preload(12'd8, 32'hAAAA0008);
        preload(12'd9, 32'hBBBB0009);
        rst = 1'b0;
        tick();

        // fetch
        access(1'b1, 32'h0C, 1'b0, 1'b0, 2'b00, 32'h0, cyc);
        chk("fetch_lat", cyc, 32'd3);
        chk("fetch_data", imem_data_in, 32'hDEADBEEF);
        chk("fetch_be", {28'h0, be_seen}, 32'h0);
        chk("fetch_en_once", en_cnt, 32'd1);
        chk("fetch_done_pulse", {30'h0, imem_done, dmem_done}, 32'd0);

        // byte store then word load
        access(1'b0, 32'h11, 1'b1, 1'b0, 2'b10, 32'h000000A5, cyc);
        chk("bst_lat", cyc, 32'd2);
        chk("bst_be", {28'h0, be_seen}, 32'h4);
        chk("bst_wdata", wd_seen, 32'hA5A5A5A5);
        chk("bst_addr", {20'h0, ra_seen}, 32'd4);
        access(1'b0, 32'h10, 1'b0, 1'b1, 2'b00, 32'h0, cyc);
        chk("wld_lat", cyc, 32'd3);
        chk("wld_data", dmem_data_in, 32'h11A53344);

        // halfword / byte loads, halfword store, load+store both high
        access(1'b0, 32'h16, 1'b0, 1'b1, 2'b01, 32'h0, cyc);
        chk("hld_lo", dmem_data_in, 32'h00005678);
        access(1'b0, 32'h14, 1'b0, 1'b1, 2'b01, 32'h0, cyc);
        chk("hld_hi", dmem_data_in, 32'h00001234);
        access(1'b0, 32'h17, 1'b0, 1'b1, 2'b10, 32'h0, cyc);
        chk("bld_lane3", dmem_data_in, 32'h00000078);
        access(1'b0, 32'h1A, 1'b1, 1'b0, 2'b01, 32'hFFFFBEEF, cyc);
        chk("hst_be", {28'h0, be_seen}, 32'h3);
        chk("hst_wdata", wd_seen, 32'hBEEFBEEF);
        access(1'b0, 32'h15, 1'b1, 1'b1, 2'b11, 32'h99999999, cyc);
        chk("rw_as_load_be", {28'h0, be_seen}, 32'h0);
        chk("rw_as_load_data", dmem_data_in, 32'h12345678);
        chk("imem_hold", imem_data_in, 32'hDEADBEEF);

        // contention: dmem first, imem four clocks later
        d_cyc = 0; i_cyc = 0;
        imem_addr = 32'h24; imem_re = 1'b1;
        dmem_addr = 32'h20; dmem_re = 1'b1; dmem_input_sel = 2'b00;
        for (int c = 1; c <= 30 && i_cyc == 0; c++) begin
            tick();
            if (dmem_done) begin d_cyc = c; dmem_re = 1'b0; end
            if (imem_done) begin i_cyc = c; imem_re = 1'b0; end
        end
        chk("cont_d_lat", d_cyc, 32'd3);
        chk("cont_i_lat", i_cyc, 32'd7);
        chk("cont_d_data", dmem_data_in, 32'hAAAA0008);
        chk("cont_i_data", imem_data_in, 32'hBBBB0009);
        tick();

        // both held: owners alternate imem, dmem, imem
        d_cnt = 0; i_cnt = 0; cyc = 0;
        imem_addr = 32'h0C; imem_re = 1'b1;
        dmem_addr = 32'h20; dmem_re = 1'b1;
        while (i_cnt < 2 && cyc < 40) begin
            tick();
            cyc++;
            if (dmem_done) d_cnt++;
            if (imem_done) i_cnt++;
        end
        imem_re = 1'b0; dmem_re = 1'b0;
        chk("alt_i_cnt", i_cnt, 32'd2);
        chk("alt_d_cnt", d_cnt, 32'd1);
        chk("alt_cycles", cyc, 32'd11);
        repeat (6) tick();

        // reset asserted during WAIT
        imem_addr = 32'h0C; imem_re = 1'b1;
        tick();
        tick();
        chk("mid_state_wait", {30'h0, fsm_state}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {imem_data_in | dmem_data_in | ram_wdata}, 32'h0);
        chk("mid_rst_ctl", {14'h0, ram_addr, ram_be, ram_en, imem_done}, 32'h0);
        imem_re = 1'b0;
        i_cnt = 0;
        repeat (3) begin
            tick();
            if (imem_done || dmem_done) i_cnt++;
        end
        chk("mid_rst_no_done", i_cnt, 32'd0);
        rst = 1'b0;
        tick();
        access(1'b1, 32'h0C, 1'b0, 1'b0, 2'b00, 32'h0, cyc);
        chk("post_rst_lat", cyc, 32'd3);
        chk("post_rst_data", imem_data_in, 32'hDEADBEEF);

        // address wrap modulo depth
        access(1'b0, 32'h4000, 1'b1, 1'b0, 2'b00, 32'hCAFEF00D, cyc);
        chk("wrap_addr", {20'h0, ra_seen}, 32'd0);
        chk("wrap_be", {28'h0, be_seen}, 32'hF);
        access(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, cyc);
        chk("wrap_load", dmem_data_in, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
